tiled_matmul_engine: RTL and testbench
======================================

TILED_MATMUL_ENGINE -- requirements
Module: tiled_matmul_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 32: signed operand width of A and B elements.
REQ-002 SHALL have parameter ACC_WIDTH, default 64: signed accumulator and C element width.
REQ-003 SHALL have parameter ROW1, default 64: rows of A and of C (M).
REQ-004 SHALL have parameter COL1, default 64: columns of A and rows of B (K).
REQ-005 SHALL have parameter COL2, default 64: columns of B and of C (N).
REQ-006 SHALL have parameters ROW_PE and COL_PE, both default 4: tile height and width of the MAC array.
REQ-007 SHALL use one clock; reset is asynchronous and active-low. Ports, clock and reset first:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request a full C = A x B run; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the run completes.
- a_rd, a_addr  out  1, clog2(ROW1*COL1)  A memory read strobe and address (row-major i*COL1+k).
- a_data  in  WIDTH  A read data, valid exactly 1 cycle after a_rd.
- b_rd, b_addr  out  1, clog2(COL1*COL2)  B memory read strobe and address (row-major k*COL2+j).
- b_data  in  WIDTH  B read data, valid exactly 1 cycle after b_rd.
- c_wr, c_addr, c_data  out  1, clog2(ROW1*COL2), ACC_WIDTH  C write strobe, address (i*COL2+j), data.

Function
REQ-008 SHALL require ROW1 % ROW_PE == 0 and COL2 % COL_PE == 0; elaboration SHALL fail otherwise.
REQ-009 SHALL implement FSM states IDLE, LOAD, WAIT, MAC, WRITE, DONE.
REQ-010 SHALL, in IDLE with start=1, clear all accumulators, set tile indices ti=0, tj=0, k=0, and enter LOAD.
REQ-011 SHALL, in LOAD, run L = max(ROW_PE,COL_PE) cycles; on cycle p, assert a_rd for row ti*ROW_PE+p when p<ROW_PE and b_rd for column tj*COL_PE+p when p<COL_PE.
REQ-012 SHALL capture a_data/b_data into operand registers a_reg[p]/b_reg[p] one cycle after each strobe; WAIT (1 cycle) captures the final return.
REQ-013 SHALL, in MAC (1 cycle), update every acc[r][c] += a_reg[r]*b_reg[c] (full 2*WIDTH signed product, sign-extended, accumulated modulo 2^ACC_WIDTH); then increment k and return to LOAD if k<COL1, else enter WRITE.
REQ-014 SHALL, in WRITE, assert c_wr for ROW_PE*COL_PE consecutive cycles, emitting acc[r][c] in row-major order (c fastest) to address (ti*ROW_PE+r)*COL2 + tj*COL_PE+c.
REQ-015 SHALL, after WRITE, clear accumulators, set k=0, advance tj (inner loop), then ti (outer loop), and enter LOAD; after the last tile enter DONE.
REQ-016 SHALL, in DONE, assert done for exactly one cycle, deassert busy in that cycle, and return to IDLE.
REQ-017 SHALL ignore start in any state other than IDLE; start held high re-triggers only after the return to IDLE.
REQ-018 SHALL complete a run in exactly T = (ROW1/ROW_PE)*(COL2/COL_PE)*(COL1*(L+2)+ROW_PE*COL_PE) cycles from LOAD entry to DONE entry.
REQ-019 SHALL keep a_rd, b_rd, c_wr low outside LOAD and WRITE respectively; addresses are don't-care when the strobe is low.

Reset
REQ-020 SHALL, on rst=0 at any time including mid-run, force state IDLE, busy=0, done=0, a_rd=b_rd=c_wr=0, all addresses and c_data 0, accumulators, operand registers and indices 0.
REQ-021 SHALL issue no memory strobe in the first cycle after rst deasserts.

Structure
REQ-022 SHALL place the FSM state enum and address-width/L helper functions in shared package matmul_pkg.
REQ-023 SHALL implement the ROW_PE x COL_PE accumulator grid as sub-module mac_array (inputs clear, enable, a_vec, b_vec; output flattened acc vector).

Verification
REQ-024 SHALL cover: ROW1=COL1=COL2=4, ROW_PE=COL_PE=2, A=B=identity -> C=identity, 4 tiles, done exactly 80 cycles after LOAD entry.
REQ-025 SHALL cover: same sizes, A all 2, B all 3 -> every C element 24, 16 c_wr pulses with addresses 0,1,4,5,2,3,6,7,8,9,12,13,10,11,14,15.
REQ-026 SHALL cover: WIDTH=8, ACC_WIDTH=16, A=-128 everywhere, B=-128 everywhere, K=4 -> C=65536 mod 2^16 = 0 (wrap-around checked).
REQ-027 SHALL cover: start pulsed again mid-run -> ignored, single done pulse, results unchanged.
REQ-028 SHALL cover: rst=0 asserted during WRITE -> all outputs 0 next edge-free instant; new start after release yields correct full C.
REQ-029 SHALL cover: ROW_PE=4, COL_PE=2 (asymmetric, L=4) -> b_rd high only first 2 LOAD cycles, a_rd all 4; C matches reference model.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared definitions for the tiled matrix-multiply engine: FSM states and
// elaboration-time sizing helpers.
package matmul_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT,
        MAC,
        WRITE,
        DONE
    } state_t;

    // Never returns zero, so a degenerate size still yields a legal vector.
    function automatic int addr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int tile_len(input int rows, input int cols);
        return (rows > cols) ? rows : cols;
    endfunction

endpackage

// File: rtl/mac_array.sv
// ROW_PE x COL_PE grid of signed multiply-accumulate cells; cell (r,c) sits at
// flattened index r*COL_PE+c of the acc vector.
module mac_array
    import matmul_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int ACC_WIDTH = 64,
    parameter int ROW_PE    = 4,
    parameter int COL_PE    = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                clear,
    input  logic                                enable,
    input  logic [ROW_PE*WIDTH-1:0]             a_vec,
    input  logic [COL_PE*WIDTH-1:0]             b_vec,
    output logic [ROW_PE*COL_PE*ACC_WIDTH-1:0]  acc
);

    for (genvar r = 0; r < ROW_PE; r++) begin : g_row
        for (genvar c = 0; c < COL_PE; c++) begin : g_col
            logic signed [2*WIDTH-1:0] prod;
            logic [ACC_WIDTH-1:0]      acc_q;

            // Operands are sign-extended before the multiply so the full product is kept.
            assign prod = (2*WIDTH)'($signed(a_vec[r*WIDTH +: WIDTH]))
                        * (2*WIDTH)'($signed(b_vec[c*WIDTH +: WIDTH]));

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    acc_q <= '0;
                end else if (clear) begin
                    acc_q <= '0;
                end else if (enable) begin
                    acc_q <= acc_q + ACC_WIDTH'(prod);
                end
            end

            assign acc[(r*COL_PE+c)*ACC_WIDTH +: ACC_WIDTH] = acc_q;
        end
    end

endmodule

// File: rtl/tiled_matmul_engine.sv
// Computes C = A x B one ROW_PE x COL_PE output tile at a time, streaming one
// column of A and one row of B per k step from external single-cycle memories.
module tiled_matmul_engine
    import matmul_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int ACC_WIDTH = 64,
    parameter int ROW1      = 64,
    parameter int COL1      = 64,
    parameter int COL2      = 64,
    parameter int ROW_PE    = 4,
    parameter int COL_PE    = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    output logic                                busy,
    output logic                                done,
    output logic                                a_rd,
    output logic [addr_width(ROW1*COL1)-1:0]    a_addr,
    input  logic [WIDTH-1:0]                    a_data,
    output logic                                b_rd,
    output logic [addr_width(COL1*COL2)-1:0]    b_addr,
    input  logic [WIDTH-1:0]                    b_data,
    output logic                                c_wr,
    output logic [addr_width(ROW1*COL2)-1:0]    c_addr,
    output logic [ACC_WIDTH-1:0]                c_data
);

    if ((ROW1 % ROW_PE) != 0 || (COL2 % COL_PE) != 0) begin : g_bad_tiling
        $error("tiled_matmul_engine: ROW1/COL2 must be multiples of ROW_PE/COL_PE");
    end

    localparam int L    = tile_len(ROW_PE, COL_PE);
    localparam int NPE  = ROW_PE * COL_PE;
    localparam int TI_N = ROW1 / ROW_PE;
    localparam int TJ_N = COL2 / COL_PE;
    localparam int AAW  = addr_width(ROW1*COL1);
    localparam int BAW  = addr_width(COL1*COL2);
    localparam int CAW  = addr_width(ROW1*COL2);
    localparam int PW   = addr_width(L);
    localparam int KW   = addr_width(COL1);
    localparam int TIW  = addr_width(TI_N);
    localparam int TJW  = addr_width(TJ_N);
    localparam int WW   = addr_width(NPE);

    localparam logic [PW-1:0]  P_LAST  = PW'(L-1);
    localparam logic [KW-1:0]  K_LAST  = KW'(COL1-1);
    localparam logic [TIW-1:0] TI_LAST = TIW'(TI_N-1);
    localparam logic [TJW-1:0] TJ_LAST = TJW'(TJ_N-1);
    localparam logic [WW-1:0]  W_LAST  = WW'(NPE-1);

    function automatic logic [AAW-1:0] a_address(input int ti_v, input int p_v, input int k_v);
        return AAW'((ti_v*ROW_PE + p_v)*COL1 + k_v);
    endfunction

    function automatic logic [BAW-1:0] b_address(input int tj_v, input int p_v, input int k_v);
        return BAW'(k_v*COL2 + tj_v*COL_PE + p_v);
    endfunction

    function automatic logic [CAW-1:0] c_address(input int ti_v, input int tj_v, input int w_v);
        return CAW'((ti_v*ROW_PE + w_v/COL_PE)*COL2 + tj_v*COL_PE + w_v%COL_PE);
    endfunction

    state_t                       state;
    logic [PW-1:0]                p;
    logic [KW-1:0]                k;
    logic [TIW-1:0]               ti;
    logic [TJW-1:0]               tj;
    logic [WW-1:0]                w;

    logic [WIDTH-1:0]             a_reg [ROW_PE];
    logic [WIDTH-1:0]             b_reg [COL_PE];
    logic                         a_pend;
    logic                         b_pend;
    logic [PW-1:0]                ld_idx;
    logic [ROW_PE*WIDTH-1:0]      a_vec;
    logic [COL_PE*WIDTH-1:0]      b_vec;
    logic [NPE*ACC_WIDTH-1:0]     acc_flat;
    logic                         mac_clear;
    logic                         mac_en;

    for (genvar r = 0; r < ROW_PE; r++) begin : g_a_vec
        assign a_vec[r*WIDTH +: WIDTH] = a_reg[r];
    end
    for (genvar c = 0; c < COL_PE; c++) begin : g_b_vec
        assign b_vec[c*WIDTH +: WIDTH] = b_reg[c];
    end

    // Accumulators are wiped while idle and on the last WRITE beat, after its value has been emitted.
    assign mac_clear = (state == IDLE) || (state == WRITE && w == W_LAST);
    assign mac_en    = (state == MAC);
    assign c_data    = c_wr ? acc_flat[int'(w)*ACC_WIDTH +: ACC_WIDTH] : '0;

    mac_array #(
        .WIDTH     (WIDTH),
        .ACC_WIDTH (ACC_WIDTH),
        .ROW_PE    (ROW_PE),
        .COL_PE    (COL_PE)
    ) u_mac_array (
        .clk    (clk),
        .rst    (rst),
        .clear  (mac_clear),
        .enable (mac_en),
        .a_vec  (a_vec),
        .b_vec  (b_vec),
        .acc    (acc_flat)
    );

    // Read data returns one cycle after the strobe, so the strobe and its slot are delayed to match.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_pend <= 1'b0;
            b_pend <= 1'b0;
            ld_idx <= '0;
            for (int r = 0; r < ROW_PE; r++) a_reg[r] <= '0;
            for (int c = 0; c < COL_PE; c++) b_reg[c] <= '0;
        end else begin
            a_pend <= a_rd;
            b_pend <= b_rd;
            ld_idx <= p;
            for (int r = 0; r < ROW_PE; r++)
                if (a_pend && int'(ld_idx) == r) a_reg[r] <= a_data;
            for (int c = 0; c < COL_PE; c++)
                if (b_pend && int'(ld_idx) == c) b_reg[c] <= b_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            a_rd   <= 1'b0;
            b_rd   <= 1'b0;
            c_wr   <= 1'b0;
            a_addr <= '0;
            b_addr <= '0;
            c_addr <= '0;
            p      <= '0;
            k      <= '0;
            ti     <= '0;
            tj     <= '0;
            w      <= '0;
        end else begin
            a_rd <= 1'b0;
            b_rd <= 1'b0;
            c_wr <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    busy   <= 1'b1;
                    ti     <= '0;
                    tj     <= '0;
                    k      <= '0;
                    p      <= '0;
                    state  <= LOAD;
                    a_rd   <= 1'b1;
                    b_rd   <= 1'b1;
                    a_addr <= '0;
                    b_addr <= '0;
                end
                LOAD: if (p == P_LAST) begin
                    state <= WAIT;
                end else begin
                    p      <= p + 1'b1;
                    a_rd   <= (int'(p) + 1 < ROW_PE);
                    b_rd   <= (int'(p) + 1 < COL_PE);
                    a_addr <= a_address(int'(ti), int'(p) + 1, int'(k));
                    b_addr <= b_address(int'(tj), int'(p) + 1, int'(k));
                end
                WAIT: state <= MAC;
                MAC: if (k == K_LAST) begin
                    state  <= WRITE;
                    w      <= '0;
                    c_wr   <= 1'b1;
                    c_addr <= c_address(int'(ti), int'(tj), 0);
                end else begin
                    k      <= k + 1'b1;
                    p      <= '0;
                    state  <= LOAD;
                    a_rd   <= 1'b1;
                    b_rd   <= 1'b1;
                    a_addr <= a_address(int'(ti), 0, int'(k) + 1);
                    b_addr <= b_address(int'(tj), 0, int'(k) + 1);
                end
                WRITE: if (w == W_LAST) begin
                    k <= '0;
                    p <= '0;
                    if (ti == TI_LAST && tj == TJ_LAST) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        state <= LOAD;
                        a_rd  <= 1'b1;
                        b_rd  <= 1'b1;
                        if (tj == TJ_LAST) begin
                            tj     <= '0;
                            ti     <= ti + 1'b1;
                            a_addr <= a_address(int'(ti) + 1, 0, 0);
                            b_addr <= b_address(0, 0, 0);
                        end else begin
                            tj     <= tj + 1'b1;
                            a_addr <= a_address(int'(ti), 0, 0);
                            b_addr <= b_address(int'(tj) + 1, 0, 0);
                        end
                    end
                end else begin
                    w      <= w + 1'b1;
                    c_wr   <= 1'b1;
                    c_addr <= c_address(int'(ti), int'(tj), int'(w) + 1);
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tiled_matmul_engine.sv
// Scoreboard bench: a 4x4x4 engine with a 2x2 PE tile and one with an
// asymmetric 4x2 tile, both 8-bit operands into 16-bit accumulators.
module tb_tiled_matmul_engine;

    localparam int W  = 8;
    localparam int AW = 16;

    typedef struct {
        int addr;
        int data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          start0 = 1'b0, busy0, done0, a_rd0, b_rd0, c_wr0;
    logic [3:0]    a_addr0, b_addr0, c_addr0;
    logic [W-1:0]  a_data0 = '0, b_data0 = '0;
    logic [AW-1:0] c_data0;

    logic          start1 = 1'b0, busy1, done1, a_rd1, b_rd1, c_wr1;
    logic [3:0]    a_addr1, b_addr1, c_addr1;
    logic [W-1:0]  a_data1 = '0, b_data1 = '0;
    logic [AW-1:0] c_data1;

    logic [W-1:0]  mem_a [2][16];
    logic [W-1:0]  mem_b [2][16];

    exp_t q0[$];
    exp_t q1[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int load_cyc [2];
    int done_cyc [2];
    int done_cnt [2];
    int a_cnt    [2];
    int b_cnt    [2];
    int burst    [2];
    int bpos_err [2];
    int busy_load[2];
    int busy_done[2];

    int order0 [16] = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
    int order1 [16] = '{0, 1, 4, 5, 8, 9, 12, 13, 2, 3, 6, 7, 10, 11, 14, 15};

    tiled_matmul_engine #(
        .WIDTH(W), .ACC_WIDTH(AW), .ROW1(4), .COL1(4), .COL2(4), .ROW_PE(2), .COL_PE(2)
    ) dut0 (
        .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0),
        .a_rd(a_rd0), .a_addr(a_addr0), .a_data(a_data0),
        .b_rd(b_rd0), .b_addr(b_addr0), .b_data(b_data0),
        .c_wr(c_wr0), .c_addr(c_addr0), .c_data(c_data0)
    );

    tiled_matmul_engine #(
        .WIDTH(W), .ACC_WIDTH(AW), .ROW1(4), .COL1(4), .COL2(4), .ROW_PE(4), .COL_PE(2)
    ) dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
        .a_rd(a_rd1), .a_addr(a_addr1), .a_data(a_data1),
        .b_rd(b_rd1), .b_addr(b_addr1), .b_data(b_data1),
        .c_wr(c_wr1), .c_addr(c_addr1), .c_data(c_data1)
    );

    // Single-cycle-latency read memories
    always @(posedge clk) begin
        if (a_rd0) a_data0 <= mem_a[0][a_addr0];
        if (b_rd0) b_data0 <= mem_b[0][b_addr0];
        if (a_rd1) a_data1 <= mem_a[1][a_addr1];
        if (b_rd1) b_data1 <= mem_b[1][b_addr1];
    end

    task automatic check_output(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic int a_val(input int pat, input int i, input int k);
        case (pat)
            0:       return (i == k) ? 1 : 0;
            1:       return 2;
            2:       return -128;
            default: return i*4 + k - 7;
        endcase
    endfunction

    function automatic int b_val(input int pat, input int k, input int j);
        case (pat)
            0:       return (k == j) ? 1 : 0;
            1:       return 3;
            2:       return -128;
            default: return 3*k - 2*j + 1;
        endcase
    endfunction

    // Hand values for the directed patterns; pattern 3 uses a plain reference product.
    function automatic int expect_c(input int pat, input int i, input int j);
        int sum;
        case (pat)
            0:       return (i == j) ? 1 : 0;
            1:       return 24;
            2:       return 0;
            default: begin
                sum = 0;
                for (int k = 0; k < 4; k++) sum += a_val(pat, i, k) * b_val(pat, k, j);
                return sum & 32'hFFFF;
            end
        endcase
    endfunction

    task automatic set_start(input int d, input logic v);
        if (d == 0) start0 = v;
        else        start1 = v;
    endtask

    task automatic apply_stimulus(input int d, input int pat);
        exp_t e;
        int   addr;
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 4; k++) begin
                mem_a[d][i*4+k] = W'(a_val(pat, i, k));
                mem_b[d][i*4+k] = W'(b_val(pat, i, k));
            end
        end
        for (int n = 0; n < 16; n++) begin
            addr   = (d == 0) ? order0[n] : order1[n];
            e.addr = addr;
            e.data = expect_c(pat, addr / 4, addr % 4);
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        load_cyc[d] = -1;
        done_cyc[d] = -1;
        done_cnt[d] = 0;
        a_cnt[d]    = 0;
        b_cnt[d]    = 0;
        burst[d]    = 0;
        bpos_err[d] = 0;
        @(posedge clk); #1 set_start(d, 1'b1);
        @(posedge clk); #1 set_start(d, 1'b0);
    endtask

    task automatic wait_done(input int d, input bit mid_start, input int t_exp,
                             input int a_exp, input int b_exp, input string name);
        int waited = 0;
        while (done_cnt[d] == 0 && waited < 1000) begin
            @(posedge clk); #1;
            waited++;
            if (mid_start && waited == 30) set_start(d, 1'b1);
            if (mid_start && waited == 31) set_start(d, 1'b0);
        end
        repeat (8) @(posedge clk);
        check_output({name, " done_pulses"}, done_cnt[d], 1);
        check_output({name, " latency"}, done_cyc[d] - load_cyc[d], t_exp);
        check_output({name, " busy_in_run"}, busy_load[d], 1);
        check_output({name, " busy_at_done"}, busy_done[d], 0);
        check_output({name, " a_rd_cycles"}, a_cnt[d], a_exp);
        check_output({name, " b_rd_cycles"}, b_cnt[d], b_exp);
        check_output({name, " b_rd_position"}, bpos_err[d], 0);
        check_output({name, " writes_left"}, (d == 0) ? q0.size() : q1.size(), 0);
    endtask

    task automatic observe(input int d, input logic a_rd, input logic b_rd, input logic c_wr,
                           input logic done, input logic busy, input int c_addr, input int c_data);
        exp_t e;
        bit   have;
        if (a_rd) begin
            a_cnt[d]++;
            if (load_cyc[d] < 0) begin
                load_cyc[d]  = cyc;
                busy_load[d] = int'(busy);
            end
            if (b_rd && burst[d] >= 2) bpos_err[d]++;
            burst[d]++;
        end else begin
            burst[d] = 0;
            if (b_rd) bpos_err[d]++;
        end
        if (b_rd) b_cnt[d]++;
        if (done) begin
            done_cnt[d]++;
            done_cyc[d]  = cyc;
            busy_done[d] = int'(busy);
        end
        if (c_wr) begin
            if (d == 0) begin
                have = q0.size() > 0;
                if (have) e = q0.pop_front();
            end else begin
                have = q1.size() > 0;
                if (have) e = q1.pop_front();
            end
            if (!have) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL dut%0d unexpected_write: got addr %0d data %0d, expected no write",
                         d, c_addr, c_data);
            end else begin
                check_output($sformatf("dut%0d c_addr", d), c_addr, e.addr);
                check_output($sformatf("dut%0d c_data[%0d]", d, e.addr), c_data, e.data);
            end
        end
    endtask

    // Monitor: samples both engines mid-cycle, away from the rising edge.
    always @(negedge clk) begin
        cyc++;
        observe(0, a_rd0, b_rd0, c_wr0, done0, busy0, int'(c_addr0), int'(c_data0));
        observe(1, a_rd1, b_rd1, c_wr1, done1, busy1, int'(c_addr1), int'(c_data1));
    end

    initial begin
        int waited;
        #2 rst = 1'b0;
        #10;
        check_output("reset dut0 ctrl", int'({busy0, done0, a_rd0, b_rd0, c_wr0}), 0);
        check_output("reset dut0 data", int'({a_addr0, b_addr0, c_addr0, c_data0}), 0);
        check_output("reset dut1 ctrl", int'({busy1, done1, a_rd1, b_rd1, c_wr1}), 0);
        check_output("reset dut1 data", int'({a_addr1, b_addr1, c_addr1, c_data1}), 0);
        @(negedge clk);
        rst = 1'b1;

        $display("[TB] identity x identity on 2x2 tiles");
        apply_stimulus(0, 0);
        wait_done(0, 1'b0, 80, 32, 32, "identity");

        $display("[TB] all-2 x all-3 with a stray start mid-run");
        apply_stimulus(0, 1);
        wait_done(0, 1'b1, 80, 32, 32, "const_mid_start");

        $display("[TB] -128 x -128 accumulator wrap");
        apply_stimulus(0, 2);
        wait_done(0, 1'b0, 80, 32, 32, "wrap");

        $display("[TB] asymmetric 4x2 tile");
        apply_stimulus(1, 3);
        wait_done(1, 1'b0, 64, 32, 16, "asym");

        $display("[TB] reset during WRITE, then full rerun");
        apply_stimulus(0, 1);
        waited = 0;
        while (!c_wr0 && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        check_output("rst_write reached_write", int'(c_wr0), 1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_output("rst_write ctrl", int'({busy0, done0, a_rd0, b_rd0, c_wr0}), 0);
        check_output("rst_write data", int'({a_addr0, b_addr0, c_addr0, c_data0}), 0);
        q0.delete();
        @(negedge clk);
        rst = 1'b1;
        apply_stimulus(0, 3);
        wait_done(0, 1'b0, 80, 32, 32, "after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
